// File: rtl/ram_access_ctrl.sv
// Request-side controller for a single-port synchronous RAM: issues one read or
// write at a time, waits out the RAM read latency and returns data with a parity check.
`timescale 1ns/1ps
module ram_access_ctrl #(
  parameter int MEM_WIDTH  = 16,
  parameter int ADDR_SIZE  = 10,
  parameter int RD_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [MEM_WIDTH-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [MEM_WIDTH-1:0] rsp_rdata,
  output logic                 rsp_parity_err,
  output logic [15:0]          err_count,
  output logic [MEM_WIDTH-1:0] ram_din,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic                 ram_wr_en,
  output logic                 ram_rd_en,
  output logic                 ram_blk_select,
  output logic                 ram_addr_en,
  output logic                 ram_dout_en,
  input  logic [MEM_WIDTH-1:0] ram_dout,
  input  logic                 ram_parity
);

  typedef enum logic [2:0] {IDLE, WRITE, READ_ISSUE, READ_WAIT, RESP} state_t;

  localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

  state_t     state;
  logic [1:0] lat_cnt;

  // NOTE: every register here uses non-blocking (<=) so all state updates
  // see the pre-edge values of each other, and reset is sampled on the clock.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      lat_cnt        <= '0;
      req_ready      <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_parity_err <= 1'b0;
      err_count      <= '0;
      ram_din        <= '0;
      ram_addr       <= '0;
      ram_wr_en      <= 1'b0;
      ram_rd_en      <= 1'b0;
      ram_blk_select <= 1'b0;
      ram_addr_en    <= 1'b0;
      ram_dout_en    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            ram_addr       <= req_addr;
            ram_din        <= req_wdata;
            req_ready      <= 1'b0;
            ram_blk_select <= 1'b1;
            ram_addr_en    <= 1'b1;
            if (req_we) begin
              state     <= WRITE;
              ram_wr_en <= 1'b1;
            end else begin
              state       <= READ_ISSUE;
              ram_rd_en   <= 1'b1;
              ram_dout_en <= 1'b1;
            end
          end
        end

        WRITE: begin
          // Ready is raised directly so back-to-back writes cost two cycles each.
          state          <= IDLE;
          ram_wr_en      <= 1'b0;
          ram_blk_select <= 1'b0;
          ram_addr_en    <= 1'b0;
          req_ready      <= 1'b1;
        end

        READ_ISSUE: begin
          state       <= READ_WAIT;
          ram_rd_en   <= 1'b0;
          ram_addr_en <= 1'b0;
          lat_cnt     <= '0;
        end

        READ_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            state          <= RESP;
            rsp_valid      <= 1'b1;
            rsp_rdata      <= ram_dout;
            rsp_parity_err <= (ram_parity != (^ram_dout));
            ram_blk_select <= 1'b0;
            ram_dout_en    <= 1'b0;
            if ((ram_parity != (^ram_dout)) && (err_count != 16'hFFFF))
              err_count <= err_count + 16'd1;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
